// File: rtl/ad_ip_jesd204_tpl_adc_capture.sv
// ad_ip_jesd204_tpl_adc_capture
// Purpose: unpacks JESD204 link beats into per-channel 16-bit samples, applies
// per-channel offset-binary / sign-extension formatting, and gates the output
// valid with an optional arm/trigger burst-capture state machine.
// Ports:
//   clk, reset                 link clock, synchronous active-high reset
//   link_valid/link_data       incoming link beat (octet g at bits [g*8 +: 8])
//   link_ready                 1 once out of reset
//   fmt_twos/fmt_sext          per-channel formatting controls
//   sync_arm/sync_disarm       single-cycle control pulses
//   sync_in                    external trigger level (clk domain)
//   capture_len                beats per burst, 0 = unlimited
//   adc_valid/adc_data         formatted samples, channel c slot j at [(c*DPW+j)*16 +: 16]
//   sync_status                1 while armed and waiting for the trigger
module ad_ip_jesd204_tpl_adc_capture #(
   parameter int unsigned NUM_LANES            = 1,
   parameter int unsigned NUM_CHANNELS         = 4,
   parameter int unsigned OCTETS_PER_BEAT      = 4,
   parameter int unsigned CONVERTER_RESOLUTION = 14,
   parameter int unsigned EXT_SYNC             = 0,
   parameter int unsigned CAPTURE_CNT_WIDTH    = 16
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      link_valid,
   input  logic [8*OCTETS_PER_BEAT*NUM_LANES-1:0]    link_data,
   output logic                                      link_ready,
   input  logic [NUM_CHANNELS-1:0]                   fmt_twos,
   input  logic [NUM_CHANNELS-1:0]                   fmt_sext,
   input  logic                                      sync_arm,
   input  logic                                      sync_disarm,
   input  logic                                      sync_in,
   input  logic [CAPTURE_CNT_WIDTH-1:0]              capture_len,
   output logic [NUM_CHANNELS-1:0]                   adc_valid,
   output logic [8*OCTETS_PER_BEAT*NUM_LANES-1:0]    adc_data,
   output logic                                      sync_status
);

   localparam int unsigned LINK_W      = 8 * OCTETS_PER_BEAT * NUM_LANES;
   localparam int unsigned DPW         = (NUM_LANES * OCTETS_PER_BEAT) / (2 * NUM_CHANNELS);
   localparam int unsigned NUM_SAMPLES = DPW * NUM_CHANNELS;
   localparam int unsigned RES         = CONVERTER_RESOLUTION;
   localparam logic [15:0] TOP_BIT     = 16'(32'd1 << (RES - 1));
   localparam logic [15:0] EXT_MASK    = 16'((32'hFFFF << RES) & 32'hFFFF);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam state_t RESET_STATE = (EXT_SYNC != 0) ? ST_IDLE : ST_RUN;

   // Right-justify the N converter bits, then optionally flip the MSB and sign-extend.
   function automatic logic [15:0] fmt_sample(input logic [15:0] raw,
                                              input logic        twos,
                                              input logic        sext);
      logic [15:0] v;
      v = raw >> (16 - RES);
      if (twos) v = v ^ TOP_BIT;
      if (sext && ((v & TOP_BIT) != 16'd0)) v = v | EXT_MASK;
      return v;
   endfunction

   logic                         s1_valid_q,    s1_valid_d;
   logic [LINK_W-1:0]            s1_data_q,     s1_data_d;
   state_t                       state_q,       state_d;
   logic [CAPTURE_CNT_WIDTH-1:0] cnt_q,         cnt_d;
   logic [CAPTURE_CNT_WIDTH-1:0] len_q,         len_d;
   logic                         sync_in_q,     sync_in_d;
   logic                         adc_valid_q,   adc_valid_d;
   logic [LINK_W-1:0]            adc_data_q,    adc_data_d;
   logic                         sync_status_q, sync_status_d;
   logic                         link_ready_q,  link_ready_d;

   logic [LINK_W-1:0]            fmt_data_c;
   logic                         run_beat_c;
   logic                         sync_edge_c;

   // Sample k is {octet 2k, octet 2k+1}; its channel is fixed at elaboration.
   for (genvar k = 0; k < NUM_SAMPLES; k++) begin : g_fmt
      localparam int unsigned CH = k / DPW;
      assign fmt_data_c[k*16 +: 16] = fmt_sample({s1_data_q[k*16 +: 8], s1_data_q[k*16+8 +: 8]},
                                                 fmt_twos[CH], fmt_sext[CH]);
   end

   // A stage-1 beat is captured only if the machine is in RUN while it sits in stage 1.
   assign run_beat_c  = s1_valid_q && (state_q == ST_RUN);
   assign sync_edge_c = sync_in && !sync_in_q;

   // Next-state and datapath logic.
   always_comb begin
      s1_valid_d    = link_valid;
      s1_data_d     = link_data;
      state_d       = state_q;
      cnt_d         = cnt_q;
      len_d         = len_q;
      sync_in_d     = sync_in;
      adc_valid_d   = run_beat_c;
      adc_data_d    = s1_valid_q ? fmt_data_c : adc_data_q;
      link_ready_d  = 1'b1;

      // Saturating count of captured beats.
      if (run_beat_c && !(&cnt_q)) cnt_d = cnt_q + CAPTURE_CNT_WIDTH'(1);

      if (EXT_SYNC == 0) begin
         state_d = ST_RUN;
      end else if (sync_disarm) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (sync_arm) state_d = ST_ARMED;
            end
            ST_ARMED: begin
               if (sync_edge_c) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
                  len_d   = capture_len;
               end
            end
            ST_RUN: begin
               // The beat that reaches capture_len is still output this cycle.
               if (run_beat_c && (len_q != '0) && ((cnt_q + CAPTURE_CNT_WIDTH'(1)) == len_q))
                  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      sync_status_d = (state_d == ST_ARMED);
   end

   // State and pipeline registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q    <= 1'b0;
         s1_data_q     <= '0;
         state_q       <= RESET_STATE;
         cnt_q         <= '0;
         len_q         <= '0;
         sync_in_q     <= 1'b0;
         adc_valid_q   <= 1'b0;
         adc_data_q    <= '0;
         sync_status_q <= 1'b0;
         link_ready_q  <= 1'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_data_q     <= s1_data_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         len_q         <= len_d;
         sync_in_q     <= sync_in_d;
         adc_valid_q   <= adc_valid_d;
         adc_data_q    <= adc_data_d;
         sync_status_q <= sync_status_d;
         link_ready_q  <= link_ready_d;
      end
   end

   assign adc_valid   = {NUM_CHANNELS{adc_valid_q}};
   assign adc_data    = adc_data_q;
   assign sync_status = sync_status_q;
   assign link_ready  = link_ready_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture.sv
// tb_ad_ip_jesd204_tpl_adc_capture
// Purpose: exercises a free-running instance (L=4, M=4, N=16, no sync) and a
// triggered instance (L=2, M=2, N=14, EXT_SYNC=1) side by side, comparing both
// every cycle against a behavioural model, plus directed scenario checks.
module tb_ad_ip_jesd204_tpl_adc_capture;

   localparam int unsigned FN = 16;
   localparam int unsigned SN = 14;
   localparam int IDLE = 0, ARMED = 1, RUN = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic         link_valid;
   logic [127:0] lnk_data;
   logic [3:0]   f_twos, f_sext;
   logic [1:0]   s_twos, s_sext;
   logic         sync_arm, sync_disarm, sync_in;
   logic [7:0]   capture_len;

   logic         f_ready, f_status, s_ready, s_status;
   logic [3:0]   f_valid;
   logic [127:0] f_adc;
   logic [1:0]   s_valid;
   logic [63:0]  s_adc;

   int n_checks = 0;
   int n_errors = 0;

   // model state
   logic         p_valid = 1'b0, p_rst = 1'b1;
   logic [127:0] p_data = '0;
   logic         fe_valid = 1'b0, se_valid = 1'b0, exp_ready = 1'b0;
   logic [127:0] fe_data = '0;
   logic [63:0]  se_data = '0;
   int           m_state = IDLE;
   int           m_len = 0, m_left = 0;
   logic         m_prev_sync = 1'b0;

   always #5 clk = ~clk;

   ad_ip_jesd204_tpl_adc_capture #(
      .NUM_LANES(4), .NUM_CHANNELS(4), .OCTETS_PER_BEAT(4),
      .CONVERTER_RESOLUTION(FN), .EXT_SYNC(0), .CAPTURE_CNT_WIDTH(8)
   ) u_free (
      .clk(clk), .reset(reset), .link_valid(link_valid), .link_data(lnk_data),
      .link_ready(f_ready), .fmt_twos(f_twos), .fmt_sext(f_sext),
      .sync_arm(sync_arm), .sync_disarm(sync_disarm), .sync_in(sync_in),
      .capture_len(capture_len), .adc_valid(f_valid), .adc_data(f_adc),
      .sync_status(f_status)
   );

   ad_ip_jesd204_tpl_adc_capture #(
      .NUM_LANES(2), .NUM_CHANNELS(2), .OCTETS_PER_BEAT(4),
      .CONVERTER_RESOLUTION(SN), .EXT_SYNC(1), .CAPTURE_CNT_WIDTH(8)
   ) u_sync (
      .clk(clk), .reset(reset), .link_valid(link_valid), .link_data(lnk_data[63:0]),
      .link_ready(s_ready), .fmt_twos(s_twos), .fmt_sext(s_sext),
      .sync_arm(sync_arm), .sync_disarm(sync_disarm), .sync_in(sync_in),
      .capture_len(capture_len), .adc_valid(s_valid), .adc_data(s_adc),
      .sync_status(s_status)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One converter sample in plain integer arithmetic.
   function automatic logic [15:0] ref_sample(input logic [15:0] raw, input int n,
                                              input bit twos, input bit sext);
      int v;
      v = int'(raw) / (1 << (16 - n));
      if (twos) v = v ^ (1 << (n - 1));
      if (sext && ((v / (1 << (n - 1))) % 2 == 1)) v = v + (65536 - (1 << n));
      return 16'(v);
   endfunction

   // Whole formatted beat: ns samples, two samples per channel.
   function automatic logic [127:0] ref_beat(input logic [127:0] d, input logic [3:0] tw,
                                             input logic [3:0] sx, input int ns, input int n);
      logic [127:0] out;
      logic [7:0]   hi, lo;
      int           c;
      out = '0;
      for (int k = 0; k < ns; k++) begin
         hi  = 8'(d >> (16 * k));
         lo  = 8'(d >> (16 * k + 8));
         c   = k / 2;
         out = out | (128'(ref_sample({hi, lo}, n, bit'(tw >> c), bit'(sx >> c))) << (16 * k));
      end
      return out;
   endfunction

   // Advance one clock, update the model from the inputs seen at that edge, check all outputs.
   task automatic step();
      logic         c_rst, c_valid, c_arm, c_dis, c_sync, beat;
      logic [127:0] c_data;
      logic [3:0]   c_ftw, c_fsx;
      logic [1:0]   c_stw, c_ssx;
      logic [7:0]   c_len;
      c_rst = reset; c_valid = link_valid; c_data = lnk_data;
      c_arm = sync_arm; c_dis = sync_disarm; c_sync = sync_in; c_len = capture_len;
      c_ftw = f_twos; c_fsx = f_sext; c_stw = s_twos; c_ssx = s_sext;
      @(posedge clk);
      beat      = p_valid && !p_rst;
      exp_ready = !c_rst;
      fe_valid  = !c_rst && beat;
      se_valid  = !c_rst && beat && (m_state == RUN);
      if (c_rst) begin
         fe_data = '0;
         se_data = '0;
      end else if (beat) begin
         fe_data = ref_beat(p_data, c_ftw, c_fsx, 8, FN);
         se_data = 64'(ref_beat({64'd0, p_data[63:0]}, {2'b00, c_stw}, {2'b00, c_ssx}, 4, SN));
      end
      if (c_rst) begin
         m_state     = IDLE;
         m_prev_sync = 1'b0;
      end else begin
         if (c_dis) m_state = IDLE;
         else if (m_state == IDLE && c_arm) m_state = ARMED;
         else if (m_state == ARMED && c_sync && !m_prev_sync) begin
            m_state = RUN;
            m_len   = int'(c_len);
            m_left  = int'(c_len);
         end else if (m_state == RUN && se_valid && m_len != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_state = IDLE;
         end
         m_prev_sync = c_sync;
      end
      p_valid = c_valid; p_rst = c_rst; p_data = c_data;
      #1;
      check_eq("f_ready",  f_ready,  exp_ready);
      check_eq("f_valid",  f_valid,  {4{fe_valid}});
      check_eq("f_data",   f_adc,    fe_data);
      check_eq("f_status", f_status, 1'b0);
      check_eq("s_ready",  s_ready,  exp_ready);
      check_eq("s_valid",  s_valid,  {2{se_valid}});
      check_eq("s_data",   s_adc,    se_data);
      check_eq("s_status", s_status, m_state == ARMED);
   endtask

   initial begin
      int cnt;
      reset = 1'b1; link_valid = 1'b0; lnk_data = '0;
      f_twos = '0; f_sext = '0; s_twos = '0; s_sext = '0;
      sync_arm = 1'b0; sync_disarm = 1'b0; sync_in = 1'b0; capture_len = '0;

      repeat (3) step();
      check_eq("rst_valid", s_valid, 2'b00);
      reset = 1'b0;
      step();
      check_eq("ready_after_rst", f_ready, 1'b1);

      // Byte order and slot mapping, two-cycle latency.
      lnk_data = '0; lnk_data[31:0] = 32'h78563412; link_valid = 1'b1;
      step();
      link_valid = 1'b0;
      step();
      check_eq("map_slot0", f_adc[15:0],  16'h1234);
      check_eq("map_slot1", f_adc[31:16], 16'h5678);
      check_eq("map_valid", f_valid,      4'hF);
      step();
      check_eq("map_valid_end", f_valid, 4'h0);

      // Offset binary to sign-extended two's complement, N=14.
      s_twos = 2'b11; s_sext = 2'b11; lnk_data = '0; link_valid = 1'b1;
      step();
      lnk_data[15:0] = 16'hFCFF;
      step();
      check_eq("fmt_zero", s_adc[15:0], 16'hE000);
      link_valid = 1'b0;
      step();
      check_eq("fmt_fffc", s_adc[15:0], 16'h1FFF);

      // Arm, trigger, 3-beat burst.
      capture_len = 8'd3; link_valid = 1'b1; lnk_data = {4{$urandom}};
      sync_arm = 1'b1;
      step();
      sync_arm = 1'b0;
      check_eq("armed_status", s_status, 1'b1);
      step(); step();
      check_eq("armed_hold", s_status, 1'b1);
      check_eq("armed_novalid", s_valid, 2'b00);
      sync_in = 1'b1;
      step();
      check_eq("edge_novalid", s_valid, 2'b00);
      check_eq("edge_status", s_status, 1'b0);
      step();
      check_eq("first_valid", s_valid, 2'b11);
      cnt = 1;
      for (int i = 0; i < 8; i++) begin
         lnk_data = {4{$urandom}};
         step();
         if (s_valid[0]) cnt++;
      end
      check_eq("burst1_len", cnt, 3);

      // Re-arm for a second burst.
      sync_in = 1'b0;
      step();
      sync_arm = 1'b1;
      step();
      sync_arm = 1'b0; sync_in = 1'b1;
      cnt = 0;
      for (int i = 0; i < 9; i++) begin
         lnk_data = {4{$urandom}};
         step();
         if (s_valid[0]) cnt++;
      end
      check_eq("burst2_len", cnt, 3);

      // Arm and disarm together: disarm wins, trigger ignored.
      sync_in = 1'b0;
      step();
      sync_arm = 1'b1; sync_disarm = 1'b1;
      step();
      sync_arm = 1'b0; sync_disarm = 1'b0;
      check_eq("armdis_status", s_status, 1'b0);
      sync_in = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (s_valid[0]) cnt++;
      end
      check_eq("armdis_novalid", cnt, 0);

      // Reset pulse mid-burst (unlimited length).
      sync_in = 1'b0; capture_len = 8'd0;
      sync_arm = 1'b1;
      step();
      sync_arm = 1'b0; sync_in = 1'b1;
      repeat (4) step();
      check_eq("run_valid", s_valid, 2'b11);
      reset = 1'b1;
      step();
      check_eq("rstpulse_s_valid", s_valid, 2'b00);
      check_eq("rstpulse_f_valid", f_valid, 4'h0);
      check_eq("rstpulse_ready",   s_ready, 1'b0);
      reset = 1'b0;
      step();
      check_eq("post_rst_s_valid", s_valid, 2'b00);
      check_eq("post_rst_f_valid", f_valid, 4'h0);
      step();
      check_eq("post_rst_idle", s_valid, 2'b00);
      check_eq("post_rst_free", f_valid, 4'hF);

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         reset       = ($urandom % 64) == 0;
         link_valid  = ($urandom % 4) != 0;
         lnk_data    = {$urandom, $urandom, $urandom, $urandom};
         sync_arm    = ($urandom % 6) == 0;
         sync_disarm = ($urandom % 25) == 0;
         if ($urandom % 3 == 0) sync_in = ~sync_in;
         capture_len = 8'($urandom % 6);
         if ($urandom % 40 == 0) begin
            f_twos = 4'($urandom); f_sext = 4'($urandom);
            s_twos = 2'($urandom); s_sext = 2'($urandom);
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
